// File: rtl/router_output_pkg.sv
// Shared types and helpers for the router output stage.
// FLIT_WIDTH falls back to 36 bits when no project-wide definition exists.
// Optional statistics counters: define ROUTER_OUTPUT_STATS_EN.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 36
`endif

package router_output_pkg;

    localparam int FLIT_WIDTH = `FLIT_WIDTH;

    typedef logic [FLIT_WIDTH-1:0] flit_t;

    // Outcome of the routing decision for the flit presented this cycle.
    typedef enum logic [1:0] {
        ROUTE_IDLE    = 2'd0,   // no flit offered, or pipeline not enabled
        ROUTE_SENT    = 2'd1,   // flit accepted onto its output VC
        ROUTE_STALL   = 2'd2,   // legal target but no downstream credit
        ROUTE_ILLEGAL = 2'd3    // target vector not exactly one-hot
    } route_status_e;

    // Ceiling log2; a value of 1 yields 0.
    function automatic int clog_b2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/router_output_if.sv
// Flit bus between the stage-2 pipeline, the output stage and the
// downstream links. The slave side is the output stage itself.
interface router_output_if
    import router_output_pkg::*;
#(
    parameter int NPORTS = 5,
    parameter int NVCS   = 2
);

    localparam int NOUTPUTS = NPORTS * NVCS;

    logic [FLIT_WIDTH-1:0]        s2_flit;
    logic                         s2_flit_valid;
    logic [NOUTPUTS-1:0]          s2_ovc_decoded;
    logic [NOUTPUTS-1:0]          credit_in;
    logic                         s2_flit_routed;
    logic [NPORTS*FLIT_WIDTH-1:0] flit_out;
    logic [NOUTPUTS-1:0]          flit_out_valid;

    modport master (
        output s2_flit,
        output s2_flit_valid,
        output s2_ovc_decoded,
        output credit_in,
        input  s2_flit_routed,
        input  flit_out,
        input  flit_out_valid
    );

    modport slave (
        input  s2_flit,
        input  s2_flit_valid,
        input  s2_ovc_decoded,
        input  credit_in,
        output s2_flit_routed,
        output flit_out,
        output flit_out_valid
    );

endinterface

// File: rtl/router_output_credit_counter.sv
// Credit counter for one output VC. Starts full (BUF_DEPTH), counts down
// on each flit sent and up on each credit returned; a return while already
// full is flagged as overflow and the count saturates.
module router_output_credit_counter
    import router_output_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int CRED_W    = clog_b2(BUF_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [CRED_W-1:0] count,
    output logic              nonzero,
    output logic              full,
    output logic              overflow
);

    localparam logic [CRED_W-1:0] DEPTH_VAL = CRED_W'(BUF_DEPTH);

    logic [CRED_W-1:0] count_reg;
    logic [CRED_W-1:0] count_next;

    // Next count: simultaneous inc/dec cancel; inc at full saturates.
    always_comb begin
        count_next = count_reg;
        overflow   = 1'b0;
        if (inc && !dec) begin
            if (count_reg == DEPTH_VAL) begin
                overflow = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end else if (dec && !inc) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Count register, restored to a full buffer on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= DEPTH_VAL;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count   = count_reg;
    assign nonzero = (count_reg != '0);
    assign full    = (count_reg == DEPTH_VAL);

endmodule

// File: rtl/router_output.sv
// Router output stage: checks credit for the stage-2 flit's decoded
// output VC, registers accepted flits onto their port, tracks per-VC
// credits, flags protocol errors and reports quiescence.
// Optional statistics counters: define ROUTER_OUTPUT_STATS_EN.
module router_output
    import router_output_pkg::*;
#(
    parameter int NPORTS    = 5,
    parameter int NVCS      = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sim_time_tick,
    router_output_if.slave   bus,
    output logic             can_increment,
    output logic             route_error,
    output logic [31:0]      stat_flits_sent,
    output logic [31:0]      stat_stall_cycles
);

    localparam int NOUTPUTS = NPORTS * NVCS;
    localparam int LOG_CRED = clog_b2(BUF_DEPTH);
    localparam int CRED_W   = LOG_CRED + 1;

    route_status_e              route_status;
    logic                       target_legal;
    logic                       credit_ok;
    logic                       routed;
    logic                       error_set;
    logic [NOUTPUTS-1:0]        credit_dec;
    logic [NOUTPUTS-1:0]        credit_nonzero;
    logic [NOUTPUTS-1:0]        credit_full;
    logic [NOUTPUTS-1:0]        credit_overflow;
    logic [NOUTPUTS*CRED_W-1:0] credit_count;
    logic                       credit_count_unused;
    logic [NPORTS-1:0]          port_hit;

    flit_t                        flit_out_reg [NPORTS];
    logic [NPORTS*FLIT_WIDTH-1:0] flit_out_flat;
    logic [NOUTPUTS-1:0]          flit_out_valid_reg;
    logic [NOUTPUTS-1:0]          flit_out_valid_next;
    logic                         route_error_reg;
    logic                         route_error_next;
    logic                         can_increment_reg;
    logic                         can_increment_next;

    // Exactly one target bit set: nonzero and clearing the lowest set bit leaves zero.
    assign target_legal = (bus.s2_ovc_decoded != '0) &&
                          ((bus.s2_ovc_decoded & (bus.s2_ovc_decoded - 1'b1)) == '0);
    assign credit_ok    = |(bus.s2_ovc_decoded & credit_nonzero);

    // Classify the offered flit; only a legal target with credit is sent.
    always_comb begin
        route_status = ROUTE_IDLE;
        if (enable && bus.s2_flit_valid) begin
            if (!target_legal) begin
                route_status = ROUTE_ILLEGAL;
            end else if (credit_ok) begin
                route_status = ROUTE_SENT;
            end else begin
                route_status = ROUTE_STALL;
            end
        end
    end

    assign routed             = (route_status == ROUTE_SENT);
    assign credit_dec         = routed ? bus.s2_ovc_decoded : '0;
    assign bus.s2_flit_routed = routed;

    // One credit counter per output VC; counting is independent of enable.
    generate
        for (genvar gi = 0; gi < NOUTPUTS; gi++) begin : g_credit
            router_output_credit_counter #(
                .BUF_DEPTH (BUF_DEPTH),
                .CRED_W    (CRED_W)
            ) u_credit_counter (
                .clock    (clock),
                .reset    (reset),
                .inc      (bus.credit_in[gi]),
                .dec      (credit_dec[gi]),
                .count    (credit_count[gi*CRED_W +: CRED_W]),
                .nonzero  (credit_nonzero[gi]),
                .full     (credit_full[gi]),
                .overflow (credit_overflow[gi])
            );
        end
    endgenerate

    // Raw levels are not needed by the decision logic (nonzero/full cover it);
    // folded into one named net so they stay visible as a probe point.
    assign credit_count_unused = ^credit_count;

    // Per-port data register: loads only when a flit is sent to one of its VCs.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            assign port_hit[gi] = |credit_dec[gi*NVCS +: NVCS];

            // Hold old data unless this port was the routing target.
            always_ff @(posedge clock) begin
                if (reset) begin
                    flit_out_reg[gi] <= '0;
                end else if (port_hit[gi]) begin
                    flit_out_reg[gi] <= bus.s2_flit;
                end
            end

            assign flit_out_flat[gi*FLIT_WIDTH +: FLIT_WIDTH] = flit_out_reg[gi];
        end
    endgenerate

    // Valid is a fresh one-cycle pulse each cycle; zero whenever nothing was sent.
    assign flit_out_valid_next = credit_dec;

    // Valid register; cleared on reset so in-flight flits are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            flit_out_valid_reg <= '0;
        end else begin
            flit_out_valid_reg <= flit_out_valid_next;
        end
    end

    assign bus.flit_out       = flit_out_flat;
    assign bus.flit_out_valid = flit_out_valid_reg;

    // Sticky error: a new error in the same cycle beats the time-tick clear.
    assign error_set = (route_status == ROUTE_ILLEGAL) || (|credit_overflow);

    always_comb begin
        route_error_next = route_error_reg;
        if (error_set) begin
            route_error_next = 1'b1;
        end else if (sim_time_tick) begin
            route_error_next = 1'b0;
        end
    end

    // Error flag register.
    always_ff @(posedge clock) begin
        if (reset) begin
            route_error_reg <= 1'b0;
        end else begin
            route_error_reg <= route_error_next;
        end
    end

    assign route_error = route_error_reg;

    // Quiescent when every credit is home, nothing is on the outputs and no flit is offered.
    assign can_increment_next = (&credit_full) && (flit_out_valid_reg == '0) &&
                                !bus.s2_flit_valid;

    // Quiescence register; rises the cycle after reset once the stage is idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            can_increment_reg <= 1'b0;
        end else begin
            can_increment_reg <= can_increment_next;
        end
    end

    assign can_increment = can_increment_reg;

`ifdef ROUTER_OUTPUT_STATS_EN
    logic [31:0] stat_flits_reg;
    logic [31:0] stat_stall_reg;

    // Free-running wrap-around counters of sent flits and stalled offers.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_flits_reg <= '0;
            stat_stall_reg <= '0;
        end else begin
            if (route_status == ROUTE_SENT) begin
                stat_flits_reg <= stat_flits_reg + 32'd1;
            end
            if ((route_status == ROUTE_STALL) || (route_status == ROUTE_ILLEGAL)) begin
                stat_stall_reg <= stat_stall_reg + 32'd1;
            end
        end
    end

    assign stat_flits_sent   = stat_flits_reg;
    assign stat_stall_cycles = stat_stall_reg;
`else
    assign stat_flits_sent   = 32'd0;
    assign stat_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_router_output.sv
// Directed testbench for router_output (NPORTS=5, NVCS=2, BUF_DEPTH=4).
// Build with ROUTER_OUTPUT_STATS_EN to exercise the statistics counters.
module tb_router_output;
    import router_output_pkg::*;

    localparam int NP = 5;
    localparam int NV = 2;
    localparam int FW = FLIT_WIDTH;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        sim_time_tick = 1'b0;
    logic        can_increment;
    logic        route_error;
    logic [31:0] stat_flits_sent;
    logic [31:0] stat_stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    router_output_if #(.NPORTS(NP), .NVCS(NV)) bus ();

    router_output #(.NPORTS(NP), .NVCS(NV), .BUF_DEPTH(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .sim_time_tick     (sim_time_tick),
        .bus               (bus.slave),
        .can_increment     (can_increment),
        .route_error       (route_error),
        .stat_flits_sent   (stat_flits_sent),
        .stat_stall_cycles (stat_stall_cycles)
    );

    always #5 clock = ~clock;

    function automatic logic [35:0] port_data(input int p);
        return bus.flit_out[p*FW +: FW];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Apply one cycle's inputs, let combinational logic settle, log the transaction.
    task automatic drive(input logic en, input logic v, input logic [9:0] dec,
                         input logic [35:0] f, input logic [9:0] cr);
        enable             = en;
        bus.s2_flit_valid  = v;
        bus.s2_ovc_decoded = dec;
        bus.s2_flit        = f;
        bus.credit_in      = cr;
        #1;
        $display("txn t=%0t en=%0b valid=%0b dec=%b flit=%h credit_in=%b routed=%0b",
                 $time, en, v, dec, f, cr, bus.s2_flit_routed);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sim_time_tick = 1'b0;
        drive(1'b1, 1'b0, 10'd0, 36'd0, 10'd0);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.flit_out_valid !== 10'd0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.flit_out_valid); end
        n_checks++; if (bus.flit_out !== '0) begin n_fail++; $display("FAIL reset_flit_out: got %h want 0", bus.flit_out); end
        n_checks++; if (route_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", route_error); end
        n_checks++; if (stat_flits_sent !== 32'd0 || stat_stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_flits_sent, stat_stall_cycles); end
        step();
        n_checks++; if (can_increment !== 1'b1) begin n_fail++; $display("FAIL reset_can_increment: got %b want 1", can_increment); end
    endtask

    task automatic test_single_route();
        do_reset();
        drive(1'b1, 1'b1, 10'b0000001000, 36'h123456789, 10'd0);
        n_checks++; if (bus.s2_flit_routed !== 1'b1) begin n_fail++; $display("FAIL single_routed: got %b want 1", bus.s2_flit_routed); end
        step();
        n_checks++; if (port_data(1) !== 36'h123456789) begin n_fail++; $display("FAIL single_port1_data: got %h want 123456789", port_data(1)); end
        n_checks++; if (bus.flit_out_valid !== 10'b0000001000) begin n_fail++; $display("FAIL single_valid: got %b want 0000001000", bus.flit_out_valid); end
        n_checks++; if (port_data(0) !== 36'd0) begin n_fail++; $display("FAIL single_port0_untouched: got %h want 0", port_data(0)); end
        n_checks++; if (can_increment !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", can_increment); end
        // Returning one credit brings output 3 back to 4 without overflow (it was 3).
        drive(1'b1, 1'b0, 10'd0, 36'd0, 10'b0000001000);
        step();
        n_checks++; if (bus.flit_out_valid !== 10'd0) begin n_fail++; $display("FAIL single_valid_one_cycle: got %b want 0", bus.flit_out_valid); end
        n_checks++; if (route_error !== 1'b0) begin n_fail++; $display("FAIL single_credit3_was_3: got err %b want 0", route_error); end
        drive(1'b1, 1'b0, 10'd0, 36'd0, 10'd0);
        step();
        n_checks++; if (can_increment !== 1'b1) begin n_fail++; $display("FAIL single_quiescent: got %b want 1", can_increment); end
        n_checks++; if (port_data(1) !== 36'h123456789) begin n_fail++; $display("FAIL single_port1_hold: got %h want 123456789", port_data(1)); end
    endtask

    task automatic test_credit_exhaustion();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 10'b1, 36'hA00000000 + 36'(k), 10'd0);
            n_checks++; if (bus.s2_flit_routed !== 1'b1) begin n_fail++; $display("FAIL exhaust_routed_%0d: got %b want 1", k, bus.s2_flit_routed); end
            step();
            n_checks++; if (bus.flit_out_valid !== 10'b1 || port_data(0) !== 36'hA00000000 + 36'(k)) begin n_fail++; $display("FAIL exhaust_out_%0d: got %b/%h want 1/%h", k, bus.flit_out_valid, port_data(0), 36'hA00000000 + 36'(k)); end
        end
        drive(1'b1, 1'b1, 10'b1, 36'h0000000B5, 10'd0);
        n_checks++; if (bus.s2_flit_routed !== 1'b0) begin n_fail++; $display("FAIL exhaust_5th_blocked: got %b want 0", bus.s2_flit_routed); end
        step();
        n_checks++; if (bus.flit_out_valid !== 10'd0 || port_data(0) !== 36'hA00000003) begin n_fail++; $display("FAIL exhaust_hold: got %b/%h want 0/a00000003", bus.flit_out_valid, port_data(0)); end
        // Credit arriving this cycle does not unblock the same cycle.
        drive(1'b1, 1'b1, 10'b1, 36'h0000000B5, 10'b1);
        n_checks++; if (bus.s2_flit_routed !== 1'b0) begin n_fail++; $display("FAIL exhaust_credit_same_cycle: got %b want 0", bus.s2_flit_routed); end
        step();
        drive(1'b1, 1'b1, 10'b1, 36'h0000000B5, 10'd0);
        n_checks++; if (bus.s2_flit_routed !== 1'b1) begin n_fail++; $display("FAIL exhaust_after_credit: got %b want 1", bus.s2_flit_routed); end
        step();
        n_checks++; if (bus.flit_out_valid !== 10'b1 || port_data(0) !== 36'h0000000B5) begin n_fail++; $display("FAIL exhaust_resend_out: got %b/%h want 1/0000000b5", bus.flit_out_valid, port_data(0)); end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 10'd0, 36'd0, 10'b1);
            step();
        end
        n_checks++; if (route_error !== 1'b0) begin n_fail++; $display("FAIL exhaust_no_error: got %b want 0", route_error); end
    endtask

    task automatic test_credit_saturation();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 10'b100, 36'hC0 + 36'(k), 10'd0);
            step();
        end
        // Route and credit on output 2 in the same cycle: level stays 2.
        drive(1'b1, 1'b1, 10'b100, 36'hC2, 10'b100);
        n_checks++; if (bus.s2_flit_routed !== 1'b1) begin n_fail++; $display("FAIL sat_simul_routed: got %b want 1", bus.s2_flit_routed); end
        step();
        n_checks++; if (bus.flit_out_valid !== 10'b100) begin n_fail++; $display("FAIL sat_simul_valid: got %b want 0000000100", bus.flit_out_valid); end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 10'd0, 36'd0, 10'b100);
            step();
            n_checks++; if (route_error !== 1'b0) begin n_fail++; $display("FAIL sat_credit_%0d_no_error: got %b want 0", k, route_error); end
        end
        drive(1'b1, 1'b0, 10'd0, 36'd0, 10'b100);
        step();
        n_checks++; if (route_error !== 1'b1) begin n_fail++; $display("FAIL sat_overflow_error: got %b want 1", route_error); end
        sim_time_tick = 1'b1;
        drive(1'b1, 1'b0, 10'd0, 36'd0, 10'd0);
        step();
        n_checks++; if (route_error !== 1'b0) begin n_fail++; $display("FAIL sat_tick_clear: got %b want 0", route_error); end
        // A fresh overflow in the tick cycle keeps the flag set.
        drive(1'b1, 1'b0, 10'd0, 36'd0, 10'b100);
        step();
        n_checks++; if (route_error !== 1'b1) begin n_fail++; $display("FAIL sat_error_beats_clear: got %b want 1", route_error); end
        drive(1'b1, 1'b0, 10'd0, 36'd0, 10'd0);
        step();
        sim_time_tick = 1'b0;
        n_checks++; if (route_error !== 1'b0) begin n_fail++; $display("FAIL sat_second_clear: got %b want 0", route_error); end
        // Saturated at 4: exactly four more flits fit.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 10'b100, 36'hD0 + 36'(k), 10'd0);
            n_checks++; if (bus.s2_flit_routed !== 1'b1) begin n_fail++; $display("FAIL sat_drain_%0d: got %b want 1", k, bus.s2_flit_routed); end
            step();
        end
        drive(1'b1, 1'b1, 10'b100, 36'hD4, 10'd0);
        n_checks++; if (bus.s2_flit_routed !== 1'b0) begin n_fail++; $display("FAIL sat_level_was_4: got %b want 0", bus.s2_flit_routed); end
        step();
    endtask

    task automatic test_illegal_target();
        do_reset();
        drive(1'b1, 1'b1, 10'd0, 36'hE1, 10'd0);
        n_checks++; if (bus.s2_flit_routed !== 1'b0) begin n_fail++; $display("FAIL illegal_zero_routed: got %b want 0", bus.s2_flit_routed); end
        step();
        n_checks++; if (bus.flit_out_valid !== 10'd0 || route_error !== 1'b1) begin n_fail++; $display("FAIL illegal_zero_out: got %b/err %b want 0/1", bus.flit_out_valid, route_error); end
        sim_time_tick = 1'b1;
        drive(1'b1, 1'b0, 10'd0, 36'd0, 10'd0);
        step();
        sim_time_tick = 1'b0;
        n_checks++; if (route_error !== 1'b0) begin n_fail++; $display("FAIL illegal_clear: got %b want 0", route_error); end
        drive(1'b1, 1'b1, 10'b11, 36'hE2, 10'd0);
        n_checks++; if (bus.s2_flit_routed !== 1'b0) begin n_fail++; $display("FAIL illegal_multi_routed: got %b want 0", bus.s2_flit_routed); end
        step();
        n_checks++; if (bus.flit_out_valid !== 10'd0 || route_error !== 1'b1 || port_data(0) !== 36'd0) begin n_fail++; $display("FAIL illegal_multi_out: got %b/err %b/%h want 0/1/0", bus.flit_out_valid, route_error, port_data(0)); end
    endtask

    task automatic test_enable();
        do_reset();
        drive(1'b0, 1'b1, 10'b0000100000, 36'hF5, 10'd0);
        n_checks++; if (bus.s2_flit_routed !== 1'b0) begin n_fail++; $display("FAIL enable_off_routed: got %b want 0", bus.s2_flit_routed); end
        step();
        n_checks++; if (bus.flit_out_valid !== 10'd0 || port_data(2) !== 36'd0) begin n_fail++; $display("FAIL enable_off_out: got %b/%h want 0/0", bus.flit_out_valid, port_data(2)); end
        n_checks++; if (route_error !== 1'b0) begin n_fail++; $display("FAIL enable_off_error: got %b want 0", route_error); end
        n_checks++; if (can_increment !== 1'b0) begin n_fail++; $display("FAIL enable_pending_flit: got %b want 0", can_increment); end
        drive(1'b1, 1'b0, 10'd0, 36'd0, 10'd0);
        step();
        n_checks++; if (can_increment !== 1'b1) begin n_fail++; $display("FAIL enable_quiescent: got %b want 1", can_increment); end
    endtask

    task automatic test_back_to_back_stats();
        logic [9:0]  dec_tab [3];
        logic [35:0] dat_tab [3];
        int          port_tab [3];
        do_reset();
        dec_tab[0] = 10'b0000000010; dat_tab[0] = 36'h111111111; port_tab[0] = 0;
        dec_tab[1] = 10'b0100000000; dat_tab[1] = 36'h222222222; port_tab[1] = 4;
        dec_tab[2] = 10'b0000100000; dat_tab[2] = 36'h333333333; port_tab[2] = 2;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, dec_tab[k], dat_tab[k], 10'd0);
            n_checks++; if (bus.s2_flit_routed !== 1'b1) begin n_fail++; $display("FAIL b2b_routed_%0d: got %b want 1", k, bus.s2_flit_routed); end
            step();
            n_checks++; if (bus.flit_out_valid !== dec_tab[k] || port_data(port_tab[k]) !== dat_tab[k]) begin n_fail++; $display("FAIL b2b_out_%0d: got %b/%h want %b/%h", k, bus.flit_out_valid, port_data(port_tab[k]), dec_tab[k], dat_tab[k]); end
        end
        n_checks++; if (port_data(0) !== 36'h111111111 || port_data(4) !== 36'h222222222) begin n_fail++; $display("FAIL b2b_hold: got %h/%h want 111111111/222222222", port_data(0), port_data(4)); end
        // Disabled offer is neither a send nor a stall.
        drive(1'b0, 1'b1, 10'b10, 36'h444444444, 10'd0);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 10'd0, 36'h555555555, 10'd0);
            step();
        end
        drive(1'b1, 1'b0, 10'd0, 36'd0, 10'd0);
        step();
`ifdef ROUTER_OUTPUT_STATS_EN
        n_checks++; if (stat_flits_sent !== 32'd3) begin n_fail++; $display("FAIL stats_flits: got %0d want 3", stat_flits_sent); end
        n_checks++; if (stat_stall_cycles !== 32'd2) begin n_fail++; $display("FAIL stats_stalls: got %0d want 2", stat_stall_cycles); end
`else
        n_checks++; if (stat_flits_sent !== 32'd0) begin n_fail++; $display("FAIL stats_flits_off: got %0d want 0", stat_flits_sent); end
        n_checks++; if (stat_stall_cycles !== 32'd0) begin n_fail++; $display("FAIL stats_stalls_off: got %0d want 0", stat_stall_cycles); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_credit_exhaustion();
        test_credit_saturation();
        test_illegal_target();
        test_enable();
        test_back_to_back_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_output.md
Name: router_output

Overview:
- Output stage of the Router; the counterpart of the input-select stage.
- Takes the stage-2 flit and its decoded output port/VC target. Checks downstream credit and registers the flit onto the selected output port.
- Returns s2_flit_routed to the input stage, which acks the source queue.
- Tracks per-output-VC credits and reports quiescence for simulation-time advance.

Parameters:
- NPORTS, 5, number of router ports.
- NVCS, 2, VCs per port; NOUTPUTS = NPORTS*NVCS, output index = port*NVCS + vc.
- BUF_DEPTH, 4, downstream buffer depth per output VC; credit reset value, must be >= 1.
- LOG_CRED, CLogB2(BUF_DEPTH), credit counter width minus 1 (counter is LOG_CRED+1 bits).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  pipeline advance enable.
- sim_time_tick  in  1  simulation-time boundary pulse (clears sticky error only).
- s2_flit  in  `FLIT_WIDTH  stage-2 flit.
- s2_flit_valid  in  1  stage-2 flit valid.
- s2_ovc_decoded  in  NOUTPUTS  one-hot output port/VC target from route logic.
- credit_in  in  NOUTPUTS  one credit returned per set bit, per cycle.
- s2_flit_routed  out  1  combinational: flit accepted this cycle.
- flit_out  out  NPORTS*`FLIT_WIDTH  registered flit per port.
- flit_out_valid  out  NOUTPUTS  registered one-cycle valid per output VC.
- can_increment  out  1  all credits home and no output valid.
- route_error  out  1  sticky error flag.
- stat_flits_sent  out  32  see Optional Feature.
- stat_stall_cycles  out  32  see Optional Feature.

Behaviour:
- Reset values:
  - credits: all = BUF_DEPTH.
  - flit_out = 0; flit_out_valid = 0; route_error = 0; stats = 0.
  - can_increment = 1 one cycle after reset.
- Target legality: target legal iff s2_ovc_decoded is exactly one-hot.
- Routing (combinational):
  - s2_flit_routed = enable & s2_flit_valid & legal & credit[target] != 0.
- Latency: routed at cycle N → flit_out[port] = s2_flit and flit_out_valid[target] = 1 at cycle N+1, for exactly one cycle.
- flit_out register update:
  - Updates only for the routed port.
  - Other ports hold their old data; their valid is 0.
- Valid register loading: when enable=0, flit_out_valid loads 0 (no holds/duplicates).
- Credit counter per output VC, next value:
  - +1 if credit_in[i] set.
  - -1 if routed to i.
  - Both set: unchanged.
  - Credits are counted regardless of enable.
- Credit saturation:
  - credit_in at BUF_DEPTH with no simultaneous decrement: counter stays at BUF_DEPTH; route_error set.
  - Decrement at 0 cannot occur (gated by the routed condition).
- Illegal target: s2_flit_valid & enable & target not one-hot (zero or multi-hot) → not routed; route_error set.
- route_error clear: sticky; cleared by reset or sim_time_tick. A same-cycle new error wins over the clear.
- can_increment:
  - Registered.
  - 1 when all counters == BUF_DEPTH, flit_out_valid == 0, and s2_flit_valid == 0.
- Reset mid-operation: in-flight output flits dropped; credits restored to BUF_DEPTH next cycle.

Optional Feature:
- Macro: ROUTER_OUTPUT_STATS_EN.
- Defined:
  - stat_flits_sent increments on each routed cycle.
  - stat_stall_cycles increments on each cycle with enable & s2_flit_valid & !s2_flit_routed.
  - Both 32-bit, wrap at 2^32, cleared by reset only.
- Undefined: both ports tied to 0; no counter logic.

Decomposition:
- const.v supplies `FLIT_WIDTH.
- math.h supplies CLogB2.
- NOUTPUTS and credit width are localparams.
- Sub-module credit_counter, parameters BUF_DEPTH.
  - Inputs: clock, reset, inc, dec.
  - Outputs: count, nonzero, full, overflow.
  - Instantiated NOUTPUTS times via generate.

Test Plan:
1. Single route: reset, s2_flit=36'h123456789, valid, s2_ovc_decoded=10'b0000001000 (port1 vc1) → s2_flit_routed=1 same cycle; next cycle flit_out[port1]=36'h123456789, flit_out_valid=10'b0000001000; credit[3]=3.
2. Credit exhaustion: 4 consecutive flits to output 0 with no credit_in → 5th flit: routed=0 and held. credit_in[0]=1 → next cycle routed=1.
3. Simultaneous credit/route on output 2 with credit=2 → credit stays 2. Then credit_in[2] pulsed 3 times with no traffic → counter saturates at 4, route_error=1. sim_time_tick → route_error=0.
4. Illegal target: s2_ovc_decoded=0 and 10'b11 with valid → routed=0, flit_out_valid=0, route_error=1.
5. enable=0 with a valid, legal flit → routed=0, no output valid. can_increment=1 after all credits home and s2_flit_valid=0.
6. With ROUTER_OUTPUT_STATS_EN: 3 routes + 2 stalled cycles → stat_flits_sent=3, stat_stall_cycles=2. Without it: both read 0.
